// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//
// Word-organised data memory that answers LSU requests through a small
// IDLE / WAIT / RESP state machine. A request is granted only in IDLE, the
// response is presented for exactly one cycle in RESP, and WAIT inserts a
// configurable number of extra cycles in between.
//
// Handshake: data_gnt_o is combinational and equals data_req_in while the
// FSM is IDLE and reset is low; a transfer is accepted on the rising edge
// where data_req_in and data_gnt_o are both 1. The answer is a one-cycle
// data_rvalid pulse WAIT_CYCLES+1 cycles later, carrying data_rdata_o,
// rd_out_data and data_err_o. There is no back-pressure on the response.
//
// Parameters
//   DEPTH        number of 32-bit words (must equal 2**ADDR_W)
//   ADDR_W       word-index width
//   WAIT_CYCLES  extra cycles between acceptance and response (0..15)
//
// Ports
//   req            clock, all state updates on its rising edge
//   reset          synchronous, active-high reset
//   data_req_in    LSU transfer request
//   data_we_in     1 = write, 0 = read
//   data_be_in     byte enables, bit i selects bits [8i+7:8i]
//   data_add_in    byte address (bits [1:0] ignored)
//   data_wdata_in  write data
//   rd_in_data     destination-register tag travelling with the request
//   data_gnt_o     request accepted this cycle
//   data_rvalid    one-cycle response strobe
//   data_rdata_o   read data (0 for writes, rejected requests, outside RESP)
//   rd_out_data    tag of the request being answered (0 outside RESP)
//   data_err_o     the answered transfer was rejected (0 outside RESP)
// -----------------------------------------------------------------------------
module data_mem_resp #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        req,
  input  logic        reset,
  input  logic        data_req_in,
  input  logic        data_we_in,
  input  logic [3:0]  data_be_in,
  input  logic [31:0] data_add_in,
  input  logic [31:0] data_wdata_in,
  input  logic [4:0]  rd_in_data,
  output logic        data_gnt_o,
  output logic        data_rvalid,
  output logic [31:0] data_rdata_o,
  output logic [4:0]  rd_out_data,
  output logic        data_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Value loaded into the down-counter when entering WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;

  // Request fields captured at acceptance.
  logic              cap_we;
  logic [3:0]        cap_be;
  logic [ADDR_W-1:0] cap_idx;
  logic [4:0]        cap_tag;
  logic              cap_rej;

  logic [31:0]       mem [DEPTH];

  // Decoded view of the live request.
  logic [ADDR_W-1:0] in_idx;
  logic              in_rej;
  logic              accept;
  logic              addr_lsb_unused;

  // Fields that feed the response word: the live request when answering
  // straight out of IDLE (WAIT_CYCLES = 0), the captured copy otherwise.
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_idx;
  logic              sel_rej;
  logic [4:0]        sel_tag;
  logic [31:0]       resp_word;

  assign addr_lsb_unused = ^data_add_in[1:0];
  assign in_idx          = data_add_in[ADDR_W+1:2];

  // Any set bit above the word-index field means the address is at or past
  // DEPTH*4; checking the upper bits avoids aliasing back onto index 0.
  assign in_rej = (|data_add_in[31:ADDR_W+2]) || (data_be_in == 4'b0000);

  assign data_gnt_o = data_req_in && (state == ST_IDLE) && !reset;
  assign accept     = data_gnt_o;

  always_comb begin
    sel_we    = cap_we;
    sel_be    = cap_be;
    sel_idx   = cap_idx;
    sel_rej   = cap_rej;
    sel_tag   = cap_tag;
    resp_word = 32'd0;
    if (state == ST_IDLE) begin
      sel_we  = data_we_in;
      sel_be  = data_be_in;
      sel_idx = in_idx;
      sel_rej = in_rej;
      sel_tag = rd_in_data;
    end
    // Only valid reads return data; disabled lanes read as zero.
    if (!sel_we && !sel_rej) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be[i]) begin
          resp_word[8*i +: 8] = mem[sel_idx][8*i +: 8];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain: a write commits on its
  // acceptance edge and survives any later reset. Reset still blocks new
  // writes because the grant is forced low while reset is high.
  always_ff @(posedge req) begin
    if (accept && data_we_in && !in_rej) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_in[i]) begin
          mem[in_idx][8*i +: 8] <= data_wdata_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge req) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      cap_we       <= 1'b0;
      cap_be       <= 4'd0;
      cap_idx      <= '0;
      cap_tag      <= 5'd0;
      cap_rej      <= 1'b0;
      data_rvalid  <= 1'b0;
      data_rdata_o <= 32'd0;
      rd_out_data  <= 5'd0;
      data_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_rvalid  <= 1'b0;
          data_rdata_o <= 32'd0;
          rd_out_data  <= 5'd0;
          data_err_o   <= 1'b0;
          if (accept) begin
            cap_we  <= data_we_in;
            cap_be  <= data_be_in;
            cap_idx <= in_idx;
            cap_tag <= rd_in_data;
            cap_rej <= in_rej;
            if (WAIT_CYCLES == 0) begin
              // Answer on the next cycle; read data is sampled right here.
              state        <= ST_RESP;
              data_rvalid  <= 1'b1;
              data_rdata_o <= resp_word;
              rd_out_data  <= sel_tag;
              data_err_o   <= sel_rej;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end

        ST_WAIT: begin
          if (cnt == 4'd0) begin
            // Sampling on the RESP entry edge lets the read see every
            // write committed while this transfer was waiting.
            state        <= ST_RESP;
            data_rvalid  <= 1'b1;
            data_rdata_o <= resp_word;
            rd_out_data  <= sel_tag;
            data_err_o   <= sel_rej;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_RESP: begin
          state        <= ST_IDLE;
          data_rvalid  <= 1'b0;
          data_rdata_o <= 32'd0;
          rd_out_data  <= 5'd0;
          data_err_o   <= 1'b0;
        end

        default: begin
          state        <= ST_IDLE;
          cnt          <= 4'd0;
          data_rvalid  <= 1'b0;
          data_rdata_o <= 32'd0;
          rd_out_data  <= 5'd0;
          data_err_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
//
// Directed bench for data_mem_resp. Three instances share one clock:
//   unit 0 : WAIT_CYCLES = 1
//   unit 1 : WAIT_CYCLES = 0
//   unit 2 : WAIT_CYCLES = 3
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

  logic              clk;
  logic [2:0]        rst;
  logic [2:0]        rq;
  logic [2:0]        we;
  logic [2:0][3:0]   be;
  logic [2:0][31:0]  addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][4:0]   tag;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [2:0][31:0]  rdata;
  logic [2:0][4:0]   rtag;
  logic [2:0]        err;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got still running, want finished");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ DUTs
  data_mem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .req(clk), .reset(rst[0]), .data_req_in(rq[0]), .data_we_in(we[0]),
    .data_be_in(be[0]), .data_add_in(addr[0]), .data_wdata_in(wdata[0]),
    .rd_in_data(tag[0]), .data_gnt_o(gnt[0]), .data_rvalid(rvalid[0]),
    .data_rdata_o(rdata[0]), .rd_out_data(rtag[0]), .data_err_o(err[0])
  );

  data_mem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .req(clk), .reset(rst[1]), .data_req_in(rq[1]), .data_we_in(we[1]),
    .data_be_in(be[1]), .data_add_in(addr[1]), .data_wdata_in(wdata[1]),
    .rd_in_data(tag[1]), .data_gnt_o(gnt[1]), .data_rvalid(rvalid[1]),
    .data_rdata_o(rdata[1]), .rd_out_data(rtag[1]), .data_err_o(err[1])
  );

  data_mem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .req(clk), .reset(rst[2]), .data_req_in(rq[2]), .data_we_in(we[2]),
    .data_be_in(be[2]), .data_add_in(addr[2]), .data_wdata_in(wdata[2]),
    .rd_in_data(tag[2]), .data_gnt_o(gnt[2]), .data_rvalid(rvalid[2]),
    .data_rdata_o(rdata[2]), .rd_out_data(rtag[2]), .data_err_o(err[2])
  );

  // ------------------------------------------------------------ scoreboard
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, obs, exp);
    end
  endtask

  function automatic int wc_of(input int u);
    case (u)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic scramble(input int u);
    we[u]    = 1'($urandom_range(0, 1));
    be[u]    = 4'($urandom_range(0, 15));
    addr[u]  = $urandom;
    wdata[u] = $urandom;
    tag[u]   = 5'($urandom_range(0, 31));
  endtask

  task automatic check_quiet(input int u, input string name);
    check($sformatf("u%0d %s rvalid", u, name), {31'd0, rvalid[u]}, 32'd0);
    check($sformatf("u%0d %s rdata", u, name), rdata[u], 32'd0);
    check($sformatf("u%0d %s rtag", u, name), {27'd0, rtag[u]}, 32'd0);
    check($sformatf("u%0d %s err", u, name), {31'd0, err[u]}, 32'd0);
  endtask

  // One full transfer: request for one cycle, then inputs are scrambled while
  // the transfer is in flight, rvalid must appear exactly WAIT_CYCLES+1
  // cycles after the request cycle and drop again the cycle after.
  task automatic xfer(input int u, input logic we_v, input logic [3:0] be_v,
                      input logic [31:0] addr_v, input logic [31:0] wdata_v,
                      input logic [4:0] tag_v, input logic [31:0] exp_rdata,
                      input logic exp_err);
    int w;
    w = wc_of(u);
    @(negedge clk);
    rq[u] = 1'b1; we[u] = we_v; be[u] = be_v;
    addr[u] = addr_v; wdata[u] = wdata_v; tag[u] = tag_v;
    #1;
    check($sformatf("u%0d gnt @%h", u, addr_v), {31'd0, gnt[u]}, 32'd1);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rq[u] = 1'b0;
        scramble(u);
      end
      #1;
      if (k <= w) begin
        check($sformatf("u%0d early rvalid k=%0d", u, k), {31'd0, rvalid[u]}, 32'd0);
      end else begin
        check($sformatf("u%0d rvalid @%h", u, addr_v), {31'd0, rvalid[u]}, 32'd1);
        check($sformatf("u%0d rdata @%h", u, addr_v), rdata[u], exp_rdata);
        check($sformatf("u%0d rtag @%h", u, addr_v), {27'd0, rtag[u]}, {27'd0, tag_v});
        check($sformatf("u%0d err @%h", u, addr_v), {31'd0, err[u]}, {31'd0, exp_err});
      end
    end
    @(negedge clk);
    #1;
    check_quiet(u, "post-resp");
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    rst = 3'b111; rq = '0; we = '0; be = '0; addr = '0; wdata = '0; tag = '0;

    // Reset: grant held low even with a request present.
    @(negedge clk);
    rq[0] = 1'b1; be[0] = 4'hF;
    #1;
    check("u0 gnt in reset", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int u = 0; u < 3; u++) check_quiet(u, "reset");
    rq = '0; rst = '0;

    // Reset and request on the same edge: nothing accepted, nothing written.
    xfer(0, 1'b1, 4'hF, 32'h30, 32'h12345678, 5'd1, 32'd0, 1'b0);
    @(negedge clk);
    rst[0] = 1'b1; rq[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF;
    addr[0] = 32'h30; wdata[0] = 32'hFFFF_FFFF; tag[0] = 5'd3;
    #1;
    check("u0 gnt req+reset", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0; rq[0] = 1'b0;
    #1;
    check_quiet(0, "after req+reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("u0 no rvalid after req+reset", {31'd0, rvalid[0]}, 32'd0);
    end
    xfer(0, 1'b0, 4'hF, 32'h30, 32'h0, 5'd4, 32'h12345678, 1'b0);

    // Basic write then read.
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 5'd5, 32'd0, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0);

    // Byte enables; the last read also uses a non-aligned address.
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 5'd1, 32'd0, 1'b0);
    xfer(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 5'd2, 32'd0, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, 5'd3, 32'h11BB33DD, 1'b0);
    xfer(0, 1'b0, 4'b0011, 32'h23, 32'h0, 5'd4, 32'h000033DD, 1'b0);

    // Out of range and zero enables must not disturb word 0.
    xfer(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 5'd6, 32'd0, 1'b0);
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 5'd8, 32'd0, 1'b1);
    xfer(0, 1'b1, 4'b0000, 32'h0, 32'h55555555, 5'd9, 32'd0, 1'b1);
    xfer(0, 1'b0, 4'b0000, 32'h0, 32'h0, 5'd10, 32'd0, 1'b1);
    xfer(0, 1'b0, 4'hF, 32'h1000, 32'h0, 5'd11, 32'd0, 1'b1);
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, 5'd12, 32'h0BADF00D, 1'b0);
    xfer(0, 1'b1, 4'hF, 32'hFFC, 32'hA5A5A5A5, 5'd13, 32'd0, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'hFFC, 32'h0, 5'd14, 32'hA5A5A5A5, 1'b0);

    // Request held through WAIT and RESP; inputs change while in flight.
    @(negedge clk);
    rq[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10; tag[0] = 5'd9;
    #1; check("hold gnt c0", {31'd0, gnt[0]}, 32'd1);
    @(negedge clk);
    addr[0] = 32'h20; tag[0] = 5'd10;
    #1; check("hold gnt c1", {31'd0, gnt[0]}, 32'd0);
    check("hold rvalid c1", {31'd0, rvalid[0]}, 32'd0);
    @(negedge clk); #1;
    check("hold gnt c2", {31'd0, gnt[0]}, 32'd0);
    check("hold rvalid c2", {31'd0, rvalid[0]}, 32'd1);
    check("hold rdata c2", rdata[0], 32'hDEADBEEF);
    check("hold rtag c2", {27'd0, rtag[0]}, 32'd9);
    @(negedge clk); #1;
    check("hold gnt c3", {31'd0, gnt[0]}, 32'd1);
    check("hold rvalid c3", {31'd0, rvalid[0]}, 32'd0);
    @(negedge clk);
    rq[0] = 1'b0;
    #1; check("hold rvalid c4", {31'd0, rvalid[0]}, 32'd0);
    @(negedge clk); #1;
    check("hold rvalid c5", {31'd0, rvalid[0]}, 32'd1);
    check("hold rdata c5", rdata[0], 32'h11BB33DD);
    check("hold rtag c5", {27'd0, rtag[0]}, 32'd10);
    check("hold err c5", {31'd0, err[0]}, 32'd0);
    @(negedge clk); #1;
    check_quiet(0, "hold end");

    // Back-to-back with WAIT_CYCLES = 0: grant and rvalid alternate.
    xfer(1, 1'b1, 4'hF, 32'h104, 32'h11110000, 5'd30, 32'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rq[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF;
      addr[1] = 32'h100 + 32'(4 * c); wdata[1] = 32'hC0DE0000 | 32'(c);
      tag[1] = 5'(c + 1);
      #1;
      check($sformatf("b2b gnt c%0d", c), {31'd0, gnt[1]}, {31'd0, (c % 2 == 0)});
      check($sformatf("b2b rvalid c%0d", c), {31'd0, rvalid[1]}, {31'd0, (c % 2 == 1)});
      if (c % 2 == 1) check($sformatf("b2b rtag c%0d", c), {27'd0, rtag[1]}, 32'(c));
    end
    @(negedge clk);
    rq[1] = 1'b0;
    #1; check_quiet(1, "b2b end");
    xfer(1, 1'b0, 4'hF, 32'h100, 32'h0, 5'd20, 32'hC0DE0000, 1'b0);
    xfer(1, 1'b0, 4'hF, 32'h104, 32'h0, 5'd21, 32'h11110000, 1'b0);
    xfer(1, 1'b0, 4'hF, 32'h108, 32'h0, 5'd22, 32'hC0DE0002, 1'b0);
    xfer(1, 1'b0, 4'hF, 32'h110, 32'h0, 5'd23, 32'hC0DE0004, 1'b0);

    // Reset in the second WAIT cycle of a read with WAIT_CYCLES = 3.
    xfer(2, 1'b1, 4'hF, 32'h40, 32'h0000CAFE, 5'd2, 32'd0, 1'b0);
    @(negedge clk);
    rq[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h40; tag[2] = 5'd11;
    #1; check("abort gnt", {31'd0, gnt[2]}, 32'd1);
    @(negedge clk);
    rq[2] = 1'b0;
    #1; check("abort rvalid w1", {31'd0, rvalid[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b1;
    #1; check("abort rvalid w2", {31'd0, rvalid[2]}, 32'd0);
    @(negedge clk); #1;
    check_quiet(2, "abort reset");
    rst[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("abort no rvalid k=%0d", k), {31'd0, rvalid[2]}, 32'd0);
    end
    xfer(2, 1'b0, 4'hF, 32'h40, 32'h0, 5'd12, 32'h0000CAFE, 1'b0);

    // A write reset in its first WAIT cycle is still committed.
    @(negedge clk);
    rq[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h44;
    wdata[2] = 32'h600DD00D; tag[2] = 5'd13;
    #1; check("wr-abort gnt", {31'd0, gnt[2]}, 32'd1);
    @(negedge clk);
    rq[2] = 1'b0; rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    #1; check_quiet(2, "wr-abort reset");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("wr-abort no rvalid k=%0d", k), {31'd0, rvalid[2]}, 32'd0);
    end
    xfer(2, 1'b0, 4'hF, 32'h44, 32'h0, 5'd14, 32'h600DD00D, 1'b0);

    // ------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, 1024: number of 32-bit words in the internal storage.
REQ-002 Parameter ADDR_W, 10: word-index width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter WAIT_CYCLES, 1: extra cycles between acceptance and response; legal range 0..15.
REQ-004 Port req, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port data_req_in, input, 1: the LSU requests a transfer.
REQ-007 Port data_we_in, input, 1: 1 selects write, 0 selects read.
REQ-008 Port data_be_in, input, 4: byte enables; bit i selects byte lane i, bits [8i+7:8i].
REQ-009 Port data_add_in, input, 32: byte address.
REQ-010 Port data_wdata_in, input, 32: write data.
REQ-011 Port rd_in_data, input, 5: destination-register tag that travels with the request.
REQ-012 Port data_gnt_o, output, 1: request accepted this cycle.
REQ-013 Port data_rvalid, output, 1: response valid, one-cycle pulse.
REQ-014 Port data_rdata_o, output, 32: read data.
REQ-015 Port rd_out_data, output, 5: tag of the request being answered.
REQ-016 Port data_err_o, output, 1: the transfer being answered was rejected.

Function
REQ-017 The block SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-018 data_gnt_o SHALL be combinational and SHALL equal data_req_in only when the state is IDLE; it SHALL be 0 in WAIT and RESP.
REQ-019 A request SHALL be accepted on a rising edge where data_req_in=1 and data_gnt_o=1.
REQ-020 On acceptance the block SHALL capture data_we_in, data_be_in, the word index data_add_in[ADDR_W+1:2] and rd_in_data.
REQ-021 data_add_in[1:0] SHALL be ignored.
REQ-022 The request SHALL be rejected when data_add_in >= DEPTH*4 or data_be_in = 4'b0000.
REQ-023 On acceptance of a valid write, the lanes with be[i]=1 SHALL be written on the acceptance edge; the other lanes SHALL be left unchanged.
REQ-024 A rejected write SHALL NOT modify storage.
REQ-025 Transitions:
- IDLE -> WAIT on acceptance when WAIT_CYCLES > 0; the down-counter SHALL load WAIT_CYCLES-1.
- IDLE -> RESP on acceptance when WAIT_CYCLES = 0.
- WAIT -> RESP when the counter reaches 0; otherwise the counter SHALL decrement.
- RESP -> IDLE unconditionally.
REQ-026 data_rvalid SHALL be 1 exactly during RESP, exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-027 Read data SHALL be sampled from storage on the edge that enters RESP, so a read observes every previously accepted write.
REQ-028 During RESP, data_rdata_o SHALL return the stored word with lanes whose captured be bit is 0 forced to 0.
REQ-029 data_rdata_o SHALL be 0 for writes, for rejected requests, and outside RESP.
REQ-030 During RESP, rd_out_data SHALL carry the captured tag; it SHALL be 0 outside RESP.
REQ-031 During RESP, data_err_o SHALL be 1 for a rejected request; it SHALL be 0 otherwise and outside RESP.
REQ-032 Maximum throughput SHALL be one transfer per WAIT_CYCLES+2 cycles.
REQ-033 data_req_in held high through WAIT and RESP SHALL be granted in the first IDLE cycle after RESP.
REQ-034 Input changes during WAIT or RESP SHALL NOT affect the transaction in flight.
REQ-035 The highest legal address, (DEPTH-1)*4, SHALL be accepted as valid; DEPTH*4 SHALL be rejected and SHALL NOT wrap to index 0.

Reset
REQ-036 With reset=1 at a rising edge, the state SHALL become IDLE and the counter 0.
REQ-037 After such a reset edge, data_rvalid, data_rdata_o, rd_out_data and data_err_o SHALL be 0.
REQ-038 data_gnt_o SHALL be 0 while reset=1.
REQ-039 Reset SHALL NOT clear storage.
REQ-040 Reset during WAIT or RESP SHALL drop the pending response, so no data_rvalid is produced.
REQ-041 A write already committed at its acceptance edge before that reset SHALL remain in storage.
REQ-042 With reset=1 and data_req_in=1 on the same edge, reset SHALL win and nothing SHALL be accepted.

Verification
REQ-043 Basic write then read, WAIT_CYCLES=1:
- Stimulus: write 0xDEADBEEF to address 0x10 with be=1111, tag 5; then read 0x10, be=1111, tag 7.
- Response: gnt in the request cycle; rvalid 2 cycles after each acceptance; the read returns rdata=0xDEADBEEF, rd_out_data=7, err=0.
REQ-044 Byte enables:
- Stimulus: write 0x11223344 to 0x20 with be=1111; write 0xAABBCCDD to 0x20 with be=0101; read 0x20 with be=1111, then with be=0011.
- Response: the be=1111 read returns 0x11BB33DD; the be=0011 read returns 0x000033DD.
REQ-045 Out of range and zero enables, DEPTH=1024:
- Stimulus: write to 0x1000, then a request with be=0000.
- Response: rvalid with err=1 and rdata=0 for both; a subsequent read of 0x0 is unaffected by either request.
- Stimulus: read 0xFFC.
- Response: accepted with err=0.
REQ-046 Back-to-back requests, WAIT_CYCLES=0:
- Stimulus: data_req_in held at 1 for 6 cycles.
- Response: gnt and rvalid alternate every cycle; 3 transfers complete; tags are returned in request order.
REQ-047 Reset mid-flight, WAIT_CYCLES=3:
- Stimulus: write 0x0000CAFE to 0x40, then a read of 0x40; assert reset in that read's second WAIT cycle.
- Response: no rvalid for the aborted read; all outputs are 0 after the reset edge; a re-issued read of 0x40 returns 0x0000CAFE.
